rsa_feeder: RTL and testbench
=============================

# rsa_feeder

Operand feeder for the systolic-array top. It fetches matrix A (X×N) and matrix B (N×Y) from two operand read ports and streams them onto the array's `Xin_val/Xin_data` and `Yin_val/Yin_data` inputs, A row by row and B column by column. It then pulses `SA_start` to launch the computation. It is the transmit end of the array's operand-input interface and sits between operand memory and the array.

## Interface
- `X`, default 3: array rows; number of A rows.
- `N`, default 4: inner dimension; elements per A row and per B column.
- `Y`, default 3: array columns; number of B columns.
- `IN_LEN`, default 8: operand width.
- `MEM_AW`, default 8: operand memory address width.
- `clk`  in  1  system clock; all logic on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; ignored unless idle.
- `a_base`  in  MEM_AW  A base address; sampled when `start` is accepted.
- `b_base`  in  MEM_AW  B base address; sampled when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance through the `SA_start` cycle.
- `done`  out  1  one-cycle pulse, coincident with `SA_start`.
- `a_rd_en`  out  1  A read strobe.
- `a_rd_addr`  out  MEM_AW  A read address.
- `a_rd_data`  in  IN_LEN  A read data, valid 1 cycle after `a_rd_en`.
- `b_rd_en`  out  1  B read strobe.
- `b_rd_addr`  out  MEM_AW  B read address.
- `b_rd_data`  in  IN_LEN  B read data, valid 1 cycle after `b_rd_en`.
- `Xin_val`  out  1  A beat valid.
- `Xin_data`  out  IN_LEN  A beat.
- `Yin_val`  out  1  B beat valid.
- `Yin_data`  out  IN_LEN  B beat.
- `SA_start`  out  1  one-cycle array launch pulse.

## Operation
- States:
  - IDLE: `start` → LOAD.
  - LOAD: issues reads; leaves for DRAIN after both streams issue their last read.
  - DRAIN: 2 cycles.
  - LAUNCH: 1 cycle; asserts `SA_start` and `done`; then → IDLE.
- A stream: X·N reads. Address = `a_base` + (i·N + k), i=0..X-1 outer, k=0..N-1 inner (row-major, consecutive).
- B stream: N·Y reads in column order, j=0..Y-1 outer, k=0..N-1 inner. Address = `b_base` + (k·Y + j), with B stored row-major.
- Both streams start in the first LOAD cycle and issue one read per cycle. They run independently; the shorter stream idles once exhausted.
- `Xin_val` = `a_rd_en` registered 1 cycle. `Xin_data` = `a_rd_data` passthrough, driven 0 when `Xin_val` is low. The same rule applies to `Yin_val`/`Yin_data`.
- Addresses are computed modulo 2^MEM_AW; wrap is silent.
- Address generation uses running adders only (+1, +Y, rebase); no multipliers.

## Timing
- Reset: all outputs 0, state IDLE, counters 0.
- Reset assertion mid-operation aborts immediately. No `SA_start` or `done` is produced. The next `start` after release begins a fresh job.
- Cycle numbering (`start` high in cycle 0, L = max(X·N, N·Y)):
  - `busy` and first read strobes: cycle 1.
  - First `Xin_val`/`Yin_val`: cycle 2.
  - Last valid beat: cycle L+1.
  - `SA_start` = `done`: cycle L+3. The 2-cycle DRAIN covers the array's input data register.
  - `busy` low: cycle L+4.
- `start` while `busy` is dropped with no effect.
- `start` in the same cycle that `busy` falls is accepted.

## Configuration
- `RSA_FEEDER_BT_EN`, defined: B is stored transposed (column-major). B address = `b_base` + (j·N + k), consecutive like A.
- `RSA_FEEDER_BT_EN`, undefined: row-major B addressing as above.
- Beat order and all timing are identical in both builds.

## Structure
- Shared package `rsa_pkg`:
  - feeder state enum (IDLE/LOAD/DRAIN/LAUNCH);
  - localparams for A length (X·N), B length (N·Y), L, and DRAIN length 2.
- Sub-module `rsa_addr_gen`: two-level counter (outer/inner limits, inner and outer strides) producing address, read strobe and a last flag.
  - Instantiated once for A and once for B.
  - Stride parameters are selected by `RSA_FEEDER_BT_EN` for the B instance.

## Test plan
- Defaults, memory word = its address, `a_base`=0, `b_base`=16, `start` in cycle 0:
  - `a_rd_addr` 0..11 in cycles 1..12;
  - `Xin_data` 0..11 in cycles 2..13;
  - `Yin_data` 16,19,22,25,17,20,23,26,18,21,24,27;
  - `SA_start` and `done` in cycle 15; `busy` low in cycle 16.
- `start` re-pulsed in cycles 5 and 15 → ignored; exactly 12 beats per stream and one `SA_start`. `start` in cycle 16 → new job.
- X=2, N=3, Y=4:
  - 6 `Xin_val` beats (cycles 2..7) and 12 `Yin_val` beats (cycles 2..13);
  - `Xin_val` low from cycle 8;
  - `SA_start` in cycle 15.
- `a_base`=250, MEM_AW=8 → A addresses 250..255 then 0..5; data follows the addresses.
- `sys_rst_n` low in cycle 6 → all outputs 0 immediately, no `SA_start`. After release, `start` → full correct job.
- `RSA_FEEDER_BT_EN` defined, `b_base`=16 → B addresses 16..27 consecutive; timing identical to scenario 1.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and default dimensions for the systolic-array operand feeder.
package rsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_LAUNCH = 2'd3
    } feeder_state_e;

    localparam int RSA_X      = 3;
    localparam int RSA_N      = 4;
    localparam int RSA_Y      = 3;
    localparam int RSA_IN_LEN = 8;
    localparam int RSA_MEM_AW = 8;

    localparam int RSA_A_LEN     = RSA_X * RSA_N;
    localparam int RSA_B_LEN     = RSA_N * RSA_Y;
    localparam int RSA_L_LEN     = (RSA_A_LEN > RSA_B_LEN) ? RSA_A_LEN : RSA_B_LEN;
    localparam int RSA_DRAIN_LEN = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int rsa_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsa_feeder_if.sv
// Operand-memory read ports plus the array-side operand stream and launch pulse.
interface rsa_feeder_if #(
    parameter int IN_LEN = 8,
    parameter int MEM_AW = 8
) ();
    logic              a_rd_en;
    logic [MEM_AW-1:0] a_rd_addr;
    logic [IN_LEN-1:0] a_rd_data;
    logic              b_rd_en;
    logic [MEM_AW-1:0] b_rd_addr;
    logic [IN_LEN-1:0] b_rd_data;
    logic              Xin_val;
    logic [IN_LEN-1:0] Xin_data;
    logic              Yin_val;
    logic [IN_LEN-1:0] Yin_data;
    logic              SA_start;

    modport master (
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output Xin_val, Xin_data, Yin_val, Yin_data, SA_start,
        input  a_rd_data, b_rd_data
    );

    modport slave (
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  Xin_val, Xin_data, Yin_val, Yin_data, SA_start,
        output a_rd_data, b_rd_data
    );
endinterface

// File: rtl/rsa_addr_gen.sv
// Two-level read-address walker built from running adders: +INNER_STRIDE per beat,
// line base advanced by OUTER_STRIDE when the inner count wraps.
module rsa_addr_gen
    import rsa_pkg::*;
#(
    parameter int OUTER        = 3,
    parameter int INNER        = 4,
    parameter int INNER_STRIDE = 1,
    parameter int OUTER_STRIDE = 4,
    parameter int AW           = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [AW-1:0] base,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          last
);
    localparam int IW = rsa_cnt_w(INNER);
    localparam int OW = rsa_cnt_w(OUTER);
    localparam logic [AW-1:0] ISTEP     = AW'(INNER_STRIDE);
    localparam logic [AW-1:0] OSTEP     = AW'(OUTER_STRIDE);
    localparam logic [IW-1:0] INNER_MAX = IW'(INNER - 1);
    localparam logic [OW-1:0] OUTER_MAX = OW'(OUTER - 1);

    logic [IW-1:0] inner_cnt;
    logic [OW-1:0] outer_cnt;
    logic [AW-1:0] line_base;
    logic          inner_end;

    assign inner_end = (inner_cnt == INNER_MAX);
    assign last      = rd_en && inner_end && (outer_cnt == OUTER_MAX);

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values; blocking here would let rd_addr see this cycle's line_base update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            line_base <= '0;
            inner_cnt <= '0;
            outer_cnt <= '0;
        end else if (go) begin
            rd_en     <= 1'b1;
            rd_addr   <= base;
            line_base <= base;
            inner_cnt <= '0;
            outer_cnt <= '0;
        end else if (rd_en) begin
            if (last) begin
                rd_en     <= 1'b0;
                inner_cnt <= '0;
                outer_cnt <= '0;
            end else if (inner_end) begin
                inner_cnt <= '0;
                outer_cnt <= outer_cnt + 1'b1;
                line_base <= line_base + OSTEP;
                rd_addr   <= line_base + OSTEP;
            end else begin
                inner_cnt <= inner_cnt + 1'b1;
                rd_addr   <= rd_addr + ISTEP;
            end
        end
    end
endmodule

// File: rtl/rsa_feeder.sv
// Operand feeder: streams A row by row and B column by column into the array, then
// pulses SA_start. Define RSA_FEEDER_BT_EN when B is stored column-major in memory.
module rsa_feeder
    import rsa_pkg::*;
#(
    parameter int X      = RSA_X,
    parameter int N      = RSA_N,
    parameter int Y      = RSA_Y,
    parameter int IN_LEN = RSA_IN_LEN,
    parameter int MEM_AW = RSA_MEM_AW
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [MEM_AW-1:0] a_base,
    input  logic [MEM_AW-1:0] b_base,
    output logic              busy,
    output logic              done,
    rsa_feeder_if.master      bus
);
`ifdef RSA_FEEDER_BT_EN
    localparam int B_INNER_STRIDE = 1;
    localparam int B_OUTER_STRIDE = N;
`else
    localparam int B_INNER_STRIDE = Y;
    localparam int B_OUTER_STRIDE = 1;
`endif
    localparam int DW = rsa_cnt_w(RSA_DRAIN_LEN);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(RSA_DRAIN_LEN - 1);

    feeder_state_e state;
    logic [DW-1:0] drain_cnt;
    logic          sa_start;
    logic          go;
    logic          a_last, b_last;
    logic          x_val, y_val;
    logic          streams_done;

    assign go = (state == ST_IDLE) && start;

    rsa_addr_gen #(
        .OUTER(X), .INNER(N), .INNER_STRIDE(1), .OUTER_STRIDE(N), .AW(MEM_AW)
    ) u_a_gen (
        .clk(clk), .rst_n(sys_rst_n), .go(go), .base(a_base),
        .rd_en(bus.a_rd_en), .rd_addr(bus.a_rd_addr), .last(a_last)
    );

    rsa_addr_gen #(
        .OUTER(Y), .INNER(N), .INNER_STRIDE(B_INNER_STRIDE),
        .OUTER_STRIDE(B_OUTER_STRIDE), .AW(MEM_AW)
    ) u_b_gen (
        .clk(clk), .rst_n(sys_rst_n), .go(go), .base(b_base),
        .rd_en(bus.b_rd_en), .rd_addr(bus.b_rd_addr), .last(b_last)
    );

    // A stream that has already run out counts as finished, so the longer one decides.
    assign streams_done = (a_last || !bus.a_rd_en) && (b_last || !bus.b_rd_en);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sa_start  <= 1'b0;
        end else begin
            done     <= 1'b0;
            sa_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (streams_done) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_MAX) begin
                        state    <= ST_LAUNCH;
                        done     <= 1'b1;
                        sa_start <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data returns one cycle after the strobe, so the delayed strobe marks each beat.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_val <= 1'b0;
            y_val <= 1'b0;
        end else begin
            x_val <= bus.a_rd_en;
            y_val <= bus.b_rd_en;
        end
    end

    assign bus.Xin_val  = x_val;
    assign bus.Yin_val  = y_val;
    assign bus.Xin_data = x_val ? bus.a_rd_data : '0;
    assign bus.Yin_data = y_val ? bus.b_rd_data : '0;
    assign bus.SA_start = sa_start;
endmodule

// File: tb/tb_rsa_feeder.sv
// Self-checking bench for rsa_feeder: a default 3x4x3 instance and a 2x3x4 instance,
// each compared cycle by cycle against address/beat lists built from matrix indices.
module tb_rsa_feeder;
    import rsa_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_base, b_base;
    bit         sel;
    int         cx, cn, cy;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    logic start0, start1;
    logic busy0, done0, busy1, done1;
    assign start0 = start && !sel;
    assign start1 = start && sel;

    rsa_feeder_if #(.IN_LEN(8), .MEM_AW(8)) bus0 ();
    rsa_feeder_if #(.IN_LEN(8), .MEM_AW(8)) bus1 ();

    rsa_feeder #(.X(3), .N(4), .Y(3), .IN_LEN(8), .MEM_AW(8)) dut0 (
        .clk(clk), .sys_rst_n(rst_n), .start(start0), .a_base(a_base), .b_base(b_base),
        .busy(busy0), .done(done0), .bus(bus0.master)
    );

    rsa_feeder #(.X(2), .N(3), .Y(4), .IN_LEN(8), .MEM_AW(8)) dut1 (
        .clk(clk), .sys_rst_n(rst_n), .start(start1), .a_base(a_base), .b_base(b_base),
        .busy(busy1), .done(done1), .bus(bus1.master)
    );

    // Synchronous operand memories: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus0.a_rd_en) bus0.a_rd_data <= mem[bus0.a_rd_addr];
        if (bus0.b_rd_en) bus0.b_rd_data <= mem[bus0.b_rd_addr];
        if (bus1.a_rd_en) bus1.a_rd_data <= mem[bus1.a_rd_addr];
        if (bus1.b_rd_en) bus1.b_rd_data <= mem[bus1.b_rd_addr];
    end

    logic       o_busy, o_done, o_sa, o_aen, o_ben, o_xval, o_yval;
    logic [7:0] o_aaddr, o_baddr, o_xdata, o_ydata;

    always_comb begin
        o_busy  = busy0;         o_done  = done0;         o_sa    = bus0.SA_start;
        o_aen   = bus0.a_rd_en;  o_aaddr = bus0.a_rd_addr;
        o_ben   = bus0.b_rd_en;  o_baddr = bus0.b_rd_addr;
        o_xval  = bus0.Xin_val;  o_xdata = bus0.Xin_data;
        o_yval  = bus0.Yin_val;  o_ydata = bus0.Yin_data;
        if (sel) begin
            o_busy  = busy1;         o_done  = done1;         o_sa    = bus1.SA_start;
            o_aen   = bus1.a_rd_en;  o_aaddr = bus1.a_rd_addr;
            o_ben   = bus1.b_rd_en;  o_baddr = bus1.b_rd_addr;
            o_xval  = bus1.Xin_val;  o_xdata = bus1.Xin_data;
            o_yval  = bus1.Yin_val;  o_ydata = bus1.Yin_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(o_busy),  0);
        check({tag, "_done"},  32'(o_done),  0);
        check({tag, "_sa"},    32'(o_sa),    0);
        check({tag, "_aen"},   32'(o_aen),   0);
        check({tag, "_aaddr"}, 32'(o_aaddr), 0);
        check({tag, "_ben"},   32'(o_ben),   0);
        check({tag, "_baddr"}, 32'(o_baddr), 0);
        check({tag, "_xval"},  32'(o_xval),  0);
        check({tag, "_xdata"}, 32'(o_xdata), 0);
        check({tag, "_yval"},  32'(o_yval),  0);
        check({tag, "_ydata"}, 32'(o_ydata), 0);
    endtask

    // One job, checked every cycle from 1 to L+4. Cycle 0 is the start cycle; when
    // pre_started is set the previous call already drove start in that cycle.
    // p1/p2 are cycles in which a stray start (with different bases) is pulsed.
    // chain re-issues start in cycle L+4 with the same bases.
    task automatic run_job(input logic [7:0] ab, input logic [7:0] bb, input bit pre_started,
                           input bit chain, input int p1, input int p2);
        logic [7:0] ea[$];
        logic [7:0] eb[$];
        int xn, ny, l;
        xn = cx * cn;
        ny = cn * cy;
        l  = (xn > ny) ? xn : ny;
        for (int i = 0; i < cx; i++)
            for (int k = 0; k < cn; k++)
                ea.push_back(8'(ab + i * cn + k));
        for (int j = 0; j < cy; j++)
            for (int k = 0; k < cn; k++) begin
`ifdef RSA_FEEDER_BT_EN
                eb.push_back(8'(bb + j * cn + k));
`else
                eb.push_back(8'(bb + k * cy + j));
`endif
            end
        if (!pre_started) begin
            @(negedge clk);
            start  = 1'b1;
            a_base = ab;
            b_base = bb;
        end
        for (int c = 1; c <= l + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy",     32'(o_busy), 32'(c <= l + 3));
            check("done",     32'(o_done), 32'(c == l + 3));
            check("SA_start", 32'(o_sa),   32'(c == l + 3));
            check("a_rd_en",  32'(o_aen),  32'(c <= xn));
            check("b_rd_en",  32'(o_ben),  32'(c <= ny));
            if (c <= xn) check("a_rd_addr", 32'(o_aaddr), 32'(ea[c-1]));
            if (c <= ny) check("b_rd_addr", 32'(o_baddr), 32'(eb[c-1]));
            check("Xin_val", 32'(o_xval), 32'(c >= 2 && c <= xn + 1));
            check("Yin_val", 32'(o_yval), 32'(c >= 2 && c <= ny + 1));
            if (c >= 2 && c <= xn + 1) check("Xin_data", 32'(o_xdata), 32'(mem[ea[c-2]]));
            else                       check("Xin_data_idle", 32'(o_xdata), 0);
            if (c >= 2 && c <= ny + 1) check("Yin_data", 32'(o_ydata), 32'(mem[eb[c-2]]));
            else                       check("Yin_data_idle", 32'(o_ydata), 0);
            if (c == p1 || c == p2) begin
                start  = 1'b1;
                a_base = ~ab;
                b_base = ~bb;
            end
            if (chain && c == l + 4) begin
                start  = 1'b1;
                a_base = ab;
                b_base = bb;
            end
        end
    endtask

    // Start a job, pull reset in cycle 6, and confirm no launch ever follows.
    task automatic abort_job(input logic [7:0] ab, input logic [7:0] bb);
        @(negedge clk);
        start  = 1'b1;
        a_base = ab;
        b_base = bb;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_before_abort", 32'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("abort_SA_start", 32'(o_sa),   0);
            check("abort_done",     32'(o_done), 0);
            check("abort_busy",     32'(o_busy), 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_base = '0;
        b_base = '0;
        sel    = 1'b0;
        cx     = RSA_X;
        cn     = RSA_N;
        cy     = RSA_Y;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Word = address; stray starts in cycles 5 and 15, then a chained job in cycle 16.
        run_job(8'd0, 8'd16, 1'b0, 1'b1, 5, 15);
        run_job(8'd0, 8'd16, 1'b1, 1'b0, -1, -1);

        // Address wrap with data following the address.
        run_job(8'd250, 8'd16, 1'b0, 1'b0, -1, -1);

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 3; t++)
            run_job(8'($urandom), 8'($urandom), 1'b0, 1'b0, -1, -1);

        abort_job(8'($urandom), 8'($urandom));
        run_job(8'($urandom), 8'($urandom), 1'b0, 1'b0, -1, -1);

        // Unequal stream lengths: 6 A beats, 12 B beats.
        sel = 1'b1;
        cx  = 2;
        cn  = 3;
        cy  = 4;
        @(negedge clk);
        check_all_zero("small_idle");
        run_job(8'($urandom), 8'($urandom), 1'b0, 1'b0, -1, -1);
        run_job(8'd250, 8'($urandom), 1'b0, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
